// File: rtl/demux1to8_deser.sv
// demux1to8_deser: serial-to-parallel frame assembler with valid/ready output and overrun flag
module demux1to8_deser #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t           state, state_n;
    logic [N-1:0]     asm_r, asm_n;
    logic [SEL_W-1:0] idx;
    logic             last, free;
    // slot steering, completed-frame view and output-slot availability
    always_comb begin
        idx        = sof ? '0 : sel;
        asm_n      = sof ? '0 : asm_r;
        asm_n[idx] = din;
        last       = din_valid && idx == SEL_W'(N - 1);
        free       = !y_valid || y_ready;
    end
    // assembly register and slot counter advance on every accepted bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_r <= '0;
            sel   <= '0;
        end else if (din_valid) begin
            asm_r <= asm_n;
            sel   <= idx + 1'b1;
        end
    end
    // output slot, handshake and sticky overrun (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y       <= last && free ? asm_n : y;
            y_valid <= last && free ? 1'b1 : y_ready ? 1'b0 : y_valid;
            overrun <= last && !free ? 1'b1 : clr_ovr ? 1'b0 : overrun;
        end
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next state: a completing bit ends the frame, any other accepted bit collects
    always_comb begin
        state_n = din_valid ? (last ? IDLE : COLLECT) : state;
    end
    // outputs decoded from state
    always_comb begin
        busy = state == COLLECT;
    end
endmodule

// File: tb/tb_demux1to8_deser.sv
// tb_demux1to8_deser: directed stimulus checked against a frame-level model and literal expectations
module tb_demux1to8_deser;
    logic       clk = 0, rst = 1, din = 0, din_valid = 0, sof = 0, y_ready = 0, clr_ovr = 0;
    logic [2:0] sel;
    logic [7:0] y;
    logic       y_valid, busy, overrun;
    int         checks = 0, errors = 0;

    demux1to8_deser #(.N(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .sel(sel), .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
    );

    always #5 clk = ~clk;

    // model: bit count within the frame, partial frame value, output buffer
    int         m_pos;
    logic [7:0] m_fr, m_y;
    bit         m_v, m_ovr;

    always @(posedge clk or posedge rst) begin : model
        int         p;
        logic [7:0] f;
        bit         v, o, done;
        if (rst) begin
            m_pos <= 0; m_fr <= 0; m_y <= 0; m_v <= 0; m_ovr <= 0;
        end else begin
            p = m_pos; f = m_fr; v = m_v; o = m_ovr; done = 0;
            if (din_valid) begin
                if (sof) begin f = 0; p = 0; end
                f = (f & ~(8'd1 << p)) | (8'(din) << p);
                p = p + 1;
                if (p == 8) begin done = 1; p = 0; end
            end
            if (v && y_ready) v = 0;
            if (done && !v) begin m_y <= f; v = 1; end
            else if (done) o = 1;
            else if (clr_ovr) o = 0;
            m_pos <= p; m_fr <= f; m_v <= v; m_ovr <= o;
        end
    end

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("sel", sel, m_pos % 8);
        chk("busy", busy, m_pos != 0);
        chk("y", y, m_y);
        chk("y_valid", y_valid, m_v);
        chk("overrun", overrun, m_ovr);
    end

    task automatic cyc(input logic v, input logic b, input logic s, input logic r, input logic c);
        @(negedge clk); #1;
        din_valid = v; din = b; sof = s; y_ready = r; clr_ovr = c;
    endtask

    task automatic idle(input logic r);
        cyc(0, 0, 0, r, 0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic r, input logic rl, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && (i == 2 || i == 5)) begin
                idle(r);
                idle(r);
            end
            cyc(1, d[i], i == 0, i == 7 ? rl : r, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_y", y, 0);
        chk("rst_yv", y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        #1 rst = 0;

        send_frame(8'hAA, 1, 1, 0);
        idle(1);
        chk("aa_y", y, 8'hAA);
        chk("aa_yv", y_valid, 1);
        chk("aa_sel", sel, 0);
        idle(1);
        chk("aa_yv_drop", y_valid, 0);

        send_frame(8'h33, 1, 1, 1);
        send_frame(8'hCC, 1, 1, 1);
        idle(1);
        chk("cc_y", y, 8'hCC);
        chk("cc_yv", y_valid, 1);
        chk("cc_ovr", overrun, 0);
        idle(1);

        send_frame(8'hAA, 0, 0, 0);
        send_frame(8'h55, 0, 0, 0);
        idle(0);
        chk("bp_y", y, 8'hAA);
        chk("bp_yv", y_valid, 1);
        chk("bp_ovr", overrun, 1);
        idle(1);
        idle(0);
        chk("bp_yv_drop", y_valid, 0);
        chk("bp_ovr_hold", overrun, 1);
        cyc(0, 0, 0, 0, 1);
        idle(0);
        chk("bp_ovr_clr", overrun, 0);

        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h0F, 0, 1, 0);
        idle(0);
        chk("sim_y", y, 8'h0F);
        chk("sim_yv", y_valid, 1);
        chk("sim_ovr", overrun, 0);
        idle(1);

        for (int i = 0; i < 4; i++) cyc(1, 1, i == 0, 1, 0);
        idle(1);
        chk("sof_busy", busy, 1);
        chk("sof_sel", sel, 4);
        send_frame(8'h81, 1, 1, 0);
        idle(1);
        chk("sof_y", y, 8'h81);
        chk("sof_ovr", overrun, 0);
        idle(0);

        send_frame(8'hFF, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1'(8'h3C >> i), i == 0, 0, 0);
        @(negedge clk); #1 rst = 1;
        din_valid = 0;
        #2;
        chk("mrst_sel", sel, 0);
        chk("mrst_y", y, 0);
        chk("mrst_yv", y_valid, 0);
        chk("mrst_busy", busy, 0);
        @(negedge clk); #1 rst = 0;
        send_frame(8'h3C, 1, 1, 0);
        idle(1);
        chk("mrst_3c", y, 8'h3C);
        chk("mrst_3c_yv", y_valid, 1);
        idle(1);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
